// File: rtl/mac_dot_ctrl_if.sv
// ---------------------------------------------------------------------------
// mac_dot_ctrl_if
//   Handshake/data bundle between a job requester / operand source / result
//   consumer (master side) and the mac_dot_ctrl controller (slave side).
//
//   Signals:
//     start        job request (sampled by the controller only in IDLE)
//     len[4:0]     operand-pair count, sampled with start
//     busy         controller is not IDLE
//     a_in, b_in   unsigned 8-bit operands
//     in_valid     operand pair present
//     in_ready     controller accepts a pair this cycle
//     result[15:0] saturating dot-product accumulator
//     result_valid result is final
//     result_ack   consumer has taken the result
//     sat          sticky saturation flag (only when MAC_DOT_SAT_FLAG_EN is
//                  defined)
// ---------------------------------------------------------------------------
interface mac_dot_ctrl_if;
    logic        start;
    logic [4:0]  len;
    logic        busy;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ack;
`ifdef MAC_DOT_SAT_FLAG_EN
    logic        sat;
`endif

    // Requester / operand source / consumer side.
    modport master (
        output start, len, a_in, b_in, in_valid, result_ack,
        input  busy, in_ready, result, result_valid
`ifdef MAC_DOT_SAT_FLAG_EN
        , input sat
`endif
    );

    // Controller side.
    modport slave (
        input  start, len, a_in, b_in, in_valid, result_ack,
        output busy, in_ready, result, result_valid
`ifdef MAC_DOT_SAT_FLAG_EN
        , output sat
`endif
    );
endinterface

// File: rtl/mac_dot_ctrl.sv
// ---------------------------------------------------------------------------
// mac_dot_ctrl
//   Saturating 8x8 unsigned dot-product controller. A job is requested with
//   start/len in IDLE; the controller then accepts exactly min(len, MAX_LEN)
//   operand pairs, accumulates a*b into a 16-bit accumulator that clamps at
//   16'hFFFF, and presents the result until it is acknowledged.
//
//   Parameters:
//     MAX_LEN   maximum operand pairs per job (1..31), default 16
//
//   Ports:
//     clock     rising-edge clock for all state
//     reset_n   asynchronous active-low reset
//     bus       mac_dot_ctrl_if.slave (start/len/busy, a_in/b_in/in_valid/
//               in_ready, result/result_valid/result_ack, optional sat)
//
//   Optional feature:
//     MAC_DOT_SAT_FLAG_EN  when defined, adds the sticky sat output, set on
//                          any beat whose 17-bit sum overflows, cleared on
//                          job start or reset.
// ---------------------------------------------------------------------------
module mac_dot_ctrl #(
    parameter int MAX_LEN = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    mac_dot_ctrl_if.slave bus
);
    localparam logic [4:0] MAX_LEN_C = 5'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] acc_reg,   acc_next;
    logic [4:0]  count_reg, count_next;
`ifdef MAC_DOT_SAT_FLAG_EN
    logic        sat_reg,   sat_next;
`endif

    logic [4:0]  len_clamped;
    logic [15:0] product;
    logic [16:0] sum;

    assign len_clamped = (bus.len > MAX_LEN_C) ? MAX_LEN_C : bus.len;
    assign product     = 16'(bus.a_in) * 16'(bus.b_in);
    // One extra bit so overflow past 16'hFFFF is visible. Because products are
    // non-negative, a clamped accumulator can never drop below 16'hFFFF again.
    assign sum         = {1'b0, acc_reg} + {1'b0, product};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
`ifdef MAC_DOT_SAT_FLAG_EN
            sat_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
`ifdef MAC_DOT_SAT_FLAG_EN
            sat_reg   <= sat_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
`ifdef MAC_DOT_SAT_FLAG_EN
        sat_next   = sat_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    acc_next   = '0;
                    count_next = len_clamped;
`ifdef MAC_DOT_SAT_FLAG_EN
                    sat_next   = 1'b0;
`endif
                    // An empty job finishes immediately with a zero result.
                    state_next = (len_clamped == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                // in_ready is 1 throughout RUN, so in_valid alone marks a beat.
                if (bus.in_valid) begin
                    acc_next   = sum[16] ? 16'hFFFF : sum[15:0];
                    count_next = count_reg - 5'd1;
`ifdef MAC_DOT_SAT_FLAG_EN
                    if (sum[16]) begin
                        sat_next = 1'b1;
                    end
`endif
                    if (count_reg == 5'd1) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even alongside ack.
                if (bus.result_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All handshake outputs decode registered state only.
    assign bus.busy         = (state_reg != IDLE);
    assign bus.in_ready     = (state_reg == RUN);
    assign bus.result_valid = (state_reg == DONE);
    assign bus.result       = acc_reg;
`ifdef MAC_DOT_SAT_FLAG_EN
    assign bus.sat          = sat_reg;
`endif
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_ctrl
//   Directed-vector bench for mac_dot_ctrl. Each job pushes its hand-computed
//   result onto a scoreboard queue; an independent monitor pops an entry when
//   result_valid rises and checks the result on every cycle it stays valid.
// ---------------------------------------------------------------------------
module tb_mac_dot_ctrl;
    logic clock;
    logic reset_n;

    mac_dot_ctrl_if bus();

    mac_dot_ctrl #(.MAX_LEN(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] res;
        logic        sat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge.
    initial begin : monitor
        exp_t cur;
        logic prev_valid;
        prev_valid = 1'b0;
        cur.res = '0;
        cur.sat = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.result_valid && !prev_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_result", 32'(bus.result_valid), 32'd0);
                    end else begin
                        cur = sb_q.pop_front();
                        $display("result 0x%04h (expected 0x%04h)", bus.result, cur.res);
                    end
                end
                if (bus.result_valid) begin
                    check("result", 32'(bus.result), 32'(cur.res));
`ifdef MAC_DOT_SAT_FLAG_EN
                    check("sat", 32'(bus.sat), 32'(cur.sat));
`endif
                end
                check("ready_vs_valid", 32'(bus.in_ready & bus.result_valid), 32'd0);
                prev_valid = bus.result_valid;
            end
        end
    end

    // All stimulus tasks start and end at posedge + 1.
    task automatic do_start(input logic [4:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.len   = '0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin @(posedge clock); #1; end
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.result_valid && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) check("result_valid_timeout", 32'(bus.result_valid), 32'd1);
    endtask

    task automatic ack_result(input int stall);
        wait_valid();
        repeat (stall) begin @(posedge clock); #1; end
        bus.result_ack = 1'b1;
        @(posedge clock); #1;
        bus.result_ack = 1'b0;
        check("ack_drops_valid", 32'(bus.result_valid), 32'd0);
        check("ack_to_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic push_exp(input logic [15:0] r, input logic s);
        exp_t e;
        e.res = r;
        e.sat = s;
        sb_q.push_back(e);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.a_in       = '0;
        bus.b_in       = '0;
        bus.in_valid   = 1'b0;
        bus.result_ack = 1'b0;

        // Reset state.
        #12;
        check("rst_busy",         32'(bus.busy),         32'd0);
        check("rst_in_ready",     32'(bus.in_ready),     32'd0);
        check("rst_result",       32'(bus.result),       32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
`ifdef MAC_DOT_SAT_FLAG_EN
        check("rst_sat",          32'(bus.sat),          32'd0);
`endif
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Three back-to-back beats: 2*3 + 4*5 + 1*1 = 27, first start right after reset.
        push_exp(16'd27, 1'b0);
        do_start(5'd3);
        check("first_start_busy", 32'(bus.busy), 32'd1);
        send_pair(8'd2, 8'd3, 0);
        send_pair(8'd4, 8'd5, 0);
        check("not_done_early", 32'(bus.result_valid), 32'd0);
        send_pair(8'd1, 8'd1, 0);
        check("valid_after_last", 32'(bus.result_valid), 32'd1);
        check("ready_low_in_done", 32'(bus.in_ready), 32'd0);
        ack_result(0);

        // Saturation: 65025 + 65025 overflows.
        push_exp(16'hFFFF, 1'b1);
        do_start(5'd2);
        send_pair(8'd255, 8'd255, 0);
        send_pair(8'd255, 8'd255, 0);
        ack_result(1);

        // Saturated accumulator stays pinned after a zero product.
        push_exp(16'hFFFF, 1'b1);
        do_start(5'd3);
        send_pair(8'd255, 8'd255, 0);
        send_pair(8'd255, 8'd255, 0);
        send_pair(8'd0, 8'd0, 0);
        ack_result(0);

        // Empty job goes straight to DONE with zero.
        push_exp(16'd0, 1'b0);
        do_start(5'd0);
        check("len0_valid", 32'(bus.result_valid), 32'd1);
        check("len0_in_ready", 32'(bus.in_ready), 32'd0);
        ack_result(0);

        // Gapped beats: 100 + 21 + 0 + 144 = 265, stalled ack, ack with start.
        bus.result_ack = 1'b1;   // ignored in IDLE
        @(posedge clock); #1;
        bus.result_ack = 1'b0;
        check("ack_in_idle", 32'(bus.busy), 32'd0);
        push_exp(16'd265, 1'b0);
        do_start(5'd4);
        send_pair(8'd10, 8'd10, 0);
        send_pair(8'd3,  8'd7,  1);
        send_pair(8'd0,  8'd200, 2);
        send_pair(8'd12, 8'd12, 3);
        wait_valid();
        repeat (5) begin @(posedge clock); #1; end
        check("stall_valid", 32'(bus.result_valid), 32'd1);
        bus.result_ack = 1'b1;
        bus.start      = 1'b1;
        bus.len        = 5'd2;
        @(posedge clock); #1;
        bus.result_ack = 1'b0;
        bus.start      = 1'b0;
        bus.len        = '0;
        check("ack_start_idle", 32'(bus.busy), 32'd0);
        check("ack_start_valid", 32'(bus.result_valid), 32'd0);
        @(posedge clock); #1;
        check("ack_start_no_job", 32'(bus.busy), 32'd0);

        // Abort mid-job with asynchronous reset.
        do_start(5'd4);
        send_pair(8'd50, 8'd50, 0);
        send_pair(8'd1, 8'd1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy",     32'(bus.busy),         32'd0);
        check("abort_in_ready", 32'(bus.in_ready),     32'd0);
        check("abort_result",   32'(bus.result),       32'd0);
        check("abort_valid",    32'(bus.result_valid), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        push_exp(16'd63, 1'b0);
        do_start(5'd1);
        send_pair(8'd7, 8'd9, 0);
        ack_result(2);

        // len above MAX_LEN clamps to 16 beats.
        push_exp(16'd16, 1'b0);
        do_start(5'd20);
        for (int i = 0; i < 16; i++) begin
            send_pair(8'd1, 8'd1, 0);
            if (i == 14) check("clamp_not_done", 32'(bus.result_valid), 32'd0);
        end
        check("clamp_done", 32'(bus.result_valid), 32'd1);
        ack_result(0);

        repeat (3) begin @(posedge clock); #1; end
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_dot_ctrl.md
MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum operand pairs per job (1..31).
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-005 SHALL have port len  input  5  operand-pair count for the job, sampled with start.
REQ-006 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-007 SHALL have port a_in  input  8  unsigned multiplicand.
REQ-008 SHALL have port b_in  input  8  unsigned multiplier.
REQ-009 SHALL have port in_valid  input  1  operand pair present on a_in and b_in.
REQ-010 SHALL have port in_ready  output  1  controller accepts a pair this cycle.
REQ-011 SHALL have port result  output  16  saturating dot-product accumulator.
REQ-012 SHALL have port result_valid  output  1  result is final.
REQ-013 SHALL have port result_ack  input  1  consumer has taken result.
REQ-014 SHALL have port sat  output  1  sticky saturation flag; present only under REQ-033.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 SHALL clear the accumulator, load count = min(len, MAX_LEN) and move to RUN on the next edge.
REQ-017 In IDLE, start=1 with len=0 SHALL move directly to DONE with result=0.
REQ-018 in_ready SHALL be 1 only in RUN, driven from registered state with no combinational path from in_valid.
REQ-019 A beat SHALL occur on every edge with in_valid=1 and in_ready=1; with in_valid=0 in RUN, nothing changes.
REQ-020 Per beat: form a 17-bit sum = acc + a_in*b_in; acc <= 16'hFFFF if sum > 16'hFFFF, else sum[15:0]; count decrements by 1.
REQ-021 Once acc = 16'hFFFF, it SHALL remain 16'hFFFF for the rest of the job.
REQ-022 On the beat where count = 1, FSM SHALL enter DONE; result_valid SHALL rise on that same edge (1-cycle latency from the last beat).
REQ-023 result SHALL equal acc at all times; consumers treat it as meaningful only while result_valid=1.
REQ-024 In DONE, result_valid=1 and result SHALL hold stable until a cycle with result_ack=1; on that edge FSM returns to IDLE and result_valid drops.
REQ-025 start SHALL be ignored in RUN and DONE, including a cycle where result_ack=1 and start=1 coincide; a new job needs start asserted in IDLE.
REQ-026 result_ack outside DONE SHALL be ignored.
REQ-027 Accepted beats per job SHALL equal the loaded count exactly; in_ready SHALL never be 1 outside RUN.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=IDLE, acc=0, count=0, result_valid=0, in_ready=0, busy=0 and sat=0.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL abort the job with no result delivered.
REQ-030 After reset_n deasserts, the first start SHALL be honoured on the first rising edge.

Configuration
REQ-031 Macro MAC_DOT_SAT_FLAG_EN SHALL control the saturation-flag feature.
REQ-032 Without the macro, port sat and its register SHALL be absent.
REQ-033 With the macro defined, sat SHALL set on any beat where the 17-bit sum exceeds 16'hFFFF, remain set through DONE, and clear on job start (REQ-016) or reset.

Verification
REQ-034 start, len=3, pairs (2,3), (4,5), (1,1) back-to-back -> result_valid one cycle after the third beat, result=27, sat=0.
REQ-035 len=2, pairs (255,255), (255,255) -> result=16'hFFFF; sat=1 when the macro is defined.
REQ-036 len=0 -> DONE one cycle after start, result=0, in_ready never asserted.
REQ-037 len=4 with in_valid gaps of 0-3 cycles, then result_ack held low 5 cycles -> result stable and valid through the stall; result_ack=1 together with start=1 -> IDLE and no new job.
REQ-038 reset_n pulsed low after 2 of 4 beats -> all outputs 0 immediately; a following start, len=1, pair (7,9) -> result=63.
